// File: rtl/register_file.sv
// Eight-entry, DATA_WIDTH-bit register file: two combinational read ports, one synchronous write port.
// Latency: reads are zero-cycle combinational; writes are visible on the read ports one edge later.
// Backpressure: none; a write is accepted on every edge that has LD high, and reads are always valid.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LD,
    input  logic [ADDR_WIDTH-1:0] SA,
    input  logic [ADDR_WIDTH-1:0] SB,
    input  logic [ADDR_WIDTH-1:0] DR,
    input  logic [DATA_WIDTH-1:0] D_IN,
    output logic [DATA_WIDTH-1:0] DATA_A,
    output logic [DATA_WIDTH-1:0] DATA_B
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage array. No entry is hardwired; R0 is an ordinary register.
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Reset clears every entry and wins over a same-cycle write; otherwise LD writes one entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (LD) begin
            regs[DR] <= D_IN;
        end
    end

    // Read ports come straight from storage, so a write to the address being read
    // shows the old value until the edge and the new value after it (no bypass).
    always_comb begin
        DATA_A = regs[SA];
        DATA_B = regs[SB];
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          CLK;
    logic          RST;
    logic          LD;
    logic [AW-1:0] SA;
    logic [AW-1:0] SB;
    logic [AW-1:0] DR;
    logic [DW-1:0] D_IN;
    logic [DW-1:0] DATA_A;
    logic [DW-1:0] DATA_B;

    int vectors     = 0;
    int miscompares = 0;

    // Reference contents, updated from the behavioural rules at every clock edge.
    logic [DW-1:0] model [DEPTH];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .LD     (LD),
        .SA     (SA),
        .SB     (SB),
        .DR     (DR),
        .D_IN   (D_IN),
        .DATA_A (DATA_A),
        .DATA_B (DATA_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge with the given controls and advance the model the same way.
    task automatic tick(input logic rst, input logic ld, input logic [AW-1:0] dr, input logic [DW-1:0] din);
        RST  = rst;
        LD   = ld;
        DR   = dr;
        D_IN = din;
        @(posedge CLK);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (ld) begin
            model[dr] = din;
        end
        #1;
        RST = 1'b0;
        LD  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] sa, input logic [AW-1:0] sb);
        SA = sa;
        SB = sb;
        #1;
        check_eq({tag, "_a"}, DATA_A, model[sa]);
        check_eq({tag, "_b"}, DATA_B, model[sb]);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            read_check(tag, AW'(i), AW'(DEPTH - 1 - i));
        end
    endtask

    initial begin
        logic [DW-1:0] held;
        RST = 1'b0; LD = 1'b0; SA = '0; SB = '0; DR = '0; D_IN = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge CLK);

        // Reset with a competing write: everything reads zero, R3 not written.
        tick(1'b1, 1'b1, 3'd3, 32'd55);
        sweep("reset");
        SA = 3'd3; #1;
        check_eq("reset_r3_literal", DATA_A, 32'd0);

        // Basic write/read on R0.
        tick(1'b0, 1'b1, 3'd0, 32'd123);
        SA = 3'd0; SB = 3'd1; #1;
        check_eq("basic_a_literal", DATA_A, 32'd123);
        check_eq("basic_b_literal", DATA_B, 32'd0);

        // Full sweep of distinct values.
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, AW'(i), 32'hA000_0000 + DW'(i));
        for (int i = 0; i < DEPTH; i++) begin
            SA = AW'(i); SB = AW'(DEPTH - 1 - i); #1;
            check_eq("sweep_a_literal", DATA_A, 32'hA000_0000 + DW'(i));
            check_eq("sweep_b_literal", DATA_B, 32'hA000_0000 + DW'(DEPTH - 1 - i));
        end

        // LD gating: several edges with LD low must not disturb R2.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 3'd2, 32'hFFFF_FFFF);
        SA = 3'd2; #1;
        check_eq("ldgate_r2", DATA_A, 32'hA000_0002);
        sweep("ldgate");

        // Read during write: old value before the edge, new value after.
        tick(1'b0, 1'b1, 3'd5, 32'd10);
        SA = 3'd5; SB = 3'd5;
        LD = 1'b1; DR = 3'd5; D_IN = 32'd20; #1;
        check_eq("rdw_before_a", DATA_A, 32'd10);
        check_eq("rdw_before_b", DATA_B, 32'd10);
        tick(1'b0, 1'b1, 3'd5, 32'd20);
        check_eq("rdw_after_a", DATA_A, 32'd20);
        check_eq("rdw_after_b", DATA_B, 32'd20);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] sa, sb, dr;
            logic [DW-1:0] din;
            logic ld, rst;
            sa  = AW'($urandom_range(0, DEPTH - 1));
            sb  = AW'($urandom_range(0, DEPTH - 1));
            dr  = AW'($urandom_range(0, DEPTH - 1));
            din = $urandom;
            ld  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 39) == 0);
            read_check("rand_pre", sa, sb);
            tick(rst, ld, dr, din);
            read_check("rand_post", sa, sb);
        end

        // Reset priority mid-run with registers loaded.
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, AW'(i), $urandom | 32'h1);
        SA = 3'd4; #1;
        held = model[4];
        check_eq("loaded_r4", DATA_A, held);
        tick(1'b1, 1'b1, 3'd4, 32'd99);
        SA = 3'd4; #1;
        check_eq("rstprio_r4_literal", DATA_A, 32'd0);
        sweep("rstprio");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Eight-entry, 32-bit general-purpose register file for the RISCVPy datapath.
- Two independent combinational read ports (A and B) serve the ALU operand buses.
- One synchronous write port is loaded from the result bus under the LD enable.
- Synchronous active-high reset clears all entries.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 3, address width; depth is 2**ADDR_WIDTH (8 entries).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous reset, active-high.
- LD  input  1  write enable for the write port.
- SA  input  ADDR_WIDTH  read address, port A.
- SB  input  ADDR_WIDTH  read address, port B.
- DR  input  ADDR_WIDTH  destination (write) address.
- D_IN  input  DATA_WIDTH  write data.
- DATA_A  output  DATA_WIDTH  contents of register SA.
- DATA_B  output  DATA_WIDTH  contents of register SB.

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits, named R0..R7 at defaults.
- No entry is hardwired. R0 is fully writable, like every other entry.

Reset:
- Reset is synchronous and active-high.
- On a rising CLK edge with RST=1, every register becomes 0.
- RST has priority over LD; a write in the same cycle is discarded.
- DATA_A and DATA_B read 0 after the reset edge, because reads are combinational from storage.
- Reset asserted mid-operation simply clears all entries at the next edge. There is no other internal state.

Write:
- On a rising CLK edge with RST=0 and LD=1, register[DR] <= D_IN.
- With LD=0, no register changes.
- Exactly one register is written per edge.
- Write latency is 1 cycle: the value is visible on the read ports after the edge.

Read:
- DATA_A = register[SA] and DATA_B = register[SB], purely combinational (zero latency).
- Outputs follow SA and SB changes within the same cycle.
- SA and SB may be equal; both ports then show the same value.
- Read during write to the same address: no bypass. Before the edge the read port shows the old value; after the edge it shows the new value.
- Unknown/X read addresses: behaviour is unspecified. X on the outputs is acceptable.
- No X-propagation handling is required.

Widths:
- D_IN is stored unmodified; there are no sign or zero extension rules.
- All addresses fully decode the depth, so there is no out-of-range case.

Power-up:
- Register contents before the first reset are undefined.
- A bench must apply RST before checking any values.

Test Plan:
- Reset: assert RST for 1 edge with LD=1, DR=3, D_IN=55 -> all 8 registers read 0 via SA/SB sweep; R3 not written.
- Basic write/read: LD=1, DR=0, D_IN=123, one edge; then LD=0, SA=0, SB=1 -> DATA_A=123, DATA_B=0.
- Full sweep: write R_i = 32'hA000_0000+i for i=0..7 on consecutive edges; read SA=i, SB=7-i -> DATA_A=A000_000i, DATA_B=A000_000(7-i).
- LD gating: LD=0, DR=2, D_IN=FFFF_FFFF, several edges -> R2 retains its prior value.
- Read-during-write: SA=SB=5 holding 10; LD=1, DR=5, D_IN=20 -> DATA_A=DATA_B=10 before the edge, 20 after the edge.
- Reset priority mid-run: with registers loaded, RST=1 and LD=1 with DR=4, D_IN=99 on the same edge -> all registers 0, R4=0.
